// File: rtl/button_pkg.sv
// Shared types and constants for the button event arbiter.
package button_pkg;

  // Per-button auto-repeat state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  // Width of the per-button millisecond counter
  localparam int MS_CNT_W = 16;

  // Default number of buttons served by the arbiter
  localparam int N_BTN_DEFAULT = 4;

endpackage

// File: rtl/btn_repeat_fsm.sv
// Per-button press / auto-repeat sequencer: emits a one-cycle event strobe
// with a flag telling whether it is the initial press or an auto-repeat.
module btn_repeat_fsm
  import button_pkg::*;
#(
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  input  logic level,
  input  logic ms_tick,
  output logic evt,
  output logic rep
);

  localparam logic [MS_CNT_W-1:0] DELAY_LAST = MS_CNT_W'(REPEAT_DELAY_MS - 1);
  localparam logic [MS_CNT_W-1:0] RATE_LAST  = MS_CNT_W'(REPEAT_RATE_MS - 1);

  btn_state_t            state;
  logic [MS_CNT_W-1:0]   ms_cnt;

  // State, millisecond counter and registered event strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ms_cnt <= '0;
      evt    <= 1'b0;
      rep    <= 1'b0;
    end else begin
      evt <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            evt    <= 1'b1;
            rep    <= 1'b0;
            ms_cnt <= '0;
            state  <= DELAY;
          end
        end
        DELAY: begin
          if (!level) begin
            ms_cnt <= '0;
            state  <= IDLE;
          end else if (ms_tick) begin
            if (ms_cnt == DELAY_LAST) begin
              evt    <= 1'b1;
              rep    <= 1'b1;
              ms_cnt <= '0;
              state  <= REPEAT;
            end else begin
              ms_cnt <= ms_cnt + MS_CNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (!level) begin
            ms_cnt <= '0;
            state  <= IDLE;
          end else if (ms_tick) begin
            if (ms_cnt == RATE_LAST) begin
              evt    <= 1'b1;
              rep    <= 1'b1;
              ms_cnt <= '0;
            end else begin
              ms_cnt <= ms_cnt + MS_CNT_W'(1);
            end
          end
        end
        default: begin
          ms_cnt <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Collects press / auto-repeat events from N_BTN buttons, parks them in
// per-button pending slots and offers them one at a time on a valid/ready
// output using round-robin arbitration.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     evt_repeat,
  output logic                     drop_pulse
);

  localparam int ID_W    = $clog2(N_BTN);
  localparam int DIV     = CLK_FREQ / 1000;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  logic [PRESC_W-1:0] presc;
  logic               ms_tick;
  logic [N_BTN-1:0]   prev;
  logic               armed;
  logic [N_BTN-1:0]   press;
  logic [N_BTN-1:0]   fsm_evt;
  logic [N_BTN-1:0]   fsm_rep;
  logic [N_BTN-1:0]   pending;
  logic [N_BTN-1:0]   rep_flag;
  logic [N_BTN-1:0]   pending_nxt;
  logic [N_BTN-1:0]   rep_nxt;
  logic               drop_nxt;
  logic [ID_W-1:0]    ptr;
  logic               grant_any;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W:0]      probe;
  logic               load;
  logic               grant;

  assign ms_tick = (presc == PRESC_LAST);

  // Free-running millisecond prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc <= '0;
    else     presc <= ms_tick ? '0 : presc + PRESC_W'(1);
  end

  // Previous level; armed blocks a press seen on the first cycle after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      prev  <= btn_level;
      armed <= 1'b1;
    end
  end

  assign press = btn_level & ~prev & {N_BTN{armed}};

  for (genvar i = 0; i < N_BTN; i++) begin : g_fsm
    btn_repeat_fsm #(
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_RATE_MS  (REPEAT_RATE_MS)
    ) u_fsm (
      .clk     (clk),
      .rst     (rst),
      .press   (press[i]),
      .level   (btn_level[i]),
      .ms_tick (ms_tick),
      .evt     (fsm_evt[i]),
      .rep     (fsm_rep[i])
    );
  end

  assign load  = !evt_valid || evt_ready;
  assign grant = load && grant_any;

  // Round-robin search starting at ptr, wrapping at N_BTN
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    probe     = '0;
    for (int k = 0; k < N_BTN; k++) begin
      probe = {1'b0, ptr} + (ID_W+1)'(k);
      if (probe >= (ID_W+1)'(N_BTN)) probe = probe - (ID_W+1)'(N_BTN);
      if (!grant_any && pending[probe[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = probe[ID_W-1:0];
      end
    end
  end

  // Pending update: grant clears first, so a same-cycle new event wins the slot
  always_comb begin
    pending_nxt = pending;
    rep_nxt     = rep_flag;
    drop_nxt    = 1'b0;
    if (grant) pending_nxt[grant_idx] = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (fsm_evt[i]) begin
        if (pending_nxt[i]) begin
          drop_nxt = 1'b1;
        end else begin
          pending_nxt[i] = 1'b1;
          rep_nxt[i]     = fsm_rep[i];
        end
      end
    end
  end

  // Pending slots, repeat flags and drop indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      rep_flag   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      rep_flag   <= rep_nxt;
      drop_pulse <= drop_nxt;
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_repeat <= 1'b0;
      ptr        <= '0;
    end else if (load) begin
      if (grant_any) begin
        evt_valid  <= 1'b1;
        evt_id     <= grant_idx;
        evt_repeat <= rep_flag[grant_idx];
        ptr        <= (grant_idx == ID_W'(N_BTN - 1)) ? '0 : grant_idx + ID_W'(1);
      end else begin
        evt_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Randomized and directed bench for button_event_arbiter with a
// behavioural reference model.
module tb_button_event_arbiter;

  localparam int CLK_FREQ = 10_000;
  localparam int NB       = 4;
  localparam int DLY      = 3;
  localparam int RATE     = 2;
  localparam int DIV      = CLK_FREQ / 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_level = 4'b0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_repeat;
  logic       drop_pulse;

  button_event_arbiter #(
    .CLK_FREQ        (CLK_FREQ),
    .N_BTN           (NB),
    .REPEAT_DELAY_MS (DLY),
    .REPEAT_RATE_MS  (RATE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_level  (btn_level),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_id     (evt_id),
    .evt_repeat (evt_repeat),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state: events seen as "ticks held since press"
  int e;
  bit m_prev[4];
  bit m_held[4];
  int m_ticks[4];
  bit m_strobe[4];
  bit m_srep[4];
  bit m_pend[4];
  bit m_rep[4];
  int m_ptr;
  bit m_valid;
  int m_id;
  bit m_erep;
  bit m_drop;

  int cyc = 0;
  int ev_cyc[$];
  int ev_id[$];
  int ev_rep[$];
  int n_drop;

  task automatic reset_model();
    e = 0;
    for (int i = 0; i < NB; i++) begin
      m_prev[i] = 0; m_held[i] = 0; m_ticks[i] = 0; m_strobe[i] = 0;
      m_srep[i] = 0; m_pend[i] = 0; m_rep[i] = 0;
    end
    m_ptr = 0; m_valid = 0; m_id = 0; m_erep = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit load;
    int g;
    int idx;
    bit np[4];
    bit nr[4];
    bit drop;
    bit tick;
    bit lvl;
    load = !m_valid || (evt_ready === 1'b1);
    g = -1;
    if (load) begin
      for (int k = 0; k < NB; k++) begin
        idx = (m_ptr + k) % NB;
        if (g < 0 && m_pend[idx]) g = idx;
      end
    end
    np = m_pend;
    nr = m_rep;
    drop = 0;
    if (g >= 0) np[g] = 0;
    for (int i = 0; i < NB; i++) begin
      if (m_strobe[i]) begin
        if (np[i]) drop = 1;
        else begin np[i] = 1; nr[i] = m_srep[i]; end
      end
    end
    if (load) begin
      if (g >= 0) begin
        m_valid = 1; m_id = g; m_erep = m_rep[g]; m_ptr = (g + 1) % NB;
      end else begin
        m_valid = 0;
      end
    end
    m_pend = np;
    m_rep  = nr;
    m_drop = drop;
    tick = (e % DIV) == DIV - 1;
    for (int i = 0; i < NB; i++) begin
      lvl = btn_level[i];
      m_strobe[i] = 0;
      if (m_held[i]) begin
        if (!lvl) m_held[i] = 0;
        else if (tick) begin
          m_ticks[i]++;
          if (m_ticks[i] == DLY || (m_ticks[i] > DLY && (m_ticks[i] - DLY) % RATE == 0)) begin
            m_strobe[i] = 1; m_srep[i] = 1;
          end
        end
      end else if (e >= 1 && lvl && !m_prev[i]) begin
        m_held[i] = 1; m_ticks[i] = 0; m_strobe[i] = 1; m_srep[i] = 0;
      end
      m_prev[i] = lvl;
    end
    e++;
  endtask

  task automatic clear_stats();
    ev_cyc.delete(); ev_id.delete(); ev_rep.delete(); n_drop = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    cyc++;
    #1;
    check_val("valid", 32'(evt_valid), 32'(m_valid));
    check_val("id", 32'(evt_id), m_id);
    check_val("repeat", 32'(evt_repeat), 32'(m_erep));
    check_val("drop", 32'(drop_pulse), 32'(m_drop));
    if (evt_valid === 1'b1) begin
      ev_cyc.push_back(cyc); ev_id.push_back(int'(evt_id)); ev_rep.push_back(int'(evt_repeat));
    end
    if (drop_pulse === 1'b1) n_drop++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", 32'(evt_valid), 0);
    check_val("rst_id", 32'(evt_id), 0);
    check_val("rst_repeat", 32'(evt_repeat), 0);
    check_val("rst_drop", 32'(drop_pulse), 0);
    rst = 1'b0;
  endtask

  task automatic align_tick();
    for (int k = 0; k < DIV && (e % DIV) != DIV - 1; k++) cycle();
  endtask

  int p;
  int bad;

  initial begin
    reset_model();
    apply_reset();
    idle(5);

    // Single short press on button 2
    clear_stats();
    btn_level = 4'b0100;
    p = cyc + 1;
    cycle();
    btn_level = 4'b0000;
    idle(40);
    check_val("short_count", ev_cyc.size(), 1);
    check_val("short_id", ev_id.size() > 0 ? ev_id[0] : 99, 2);
    check_val("short_rep", ev_rep.size() > 0 ? ev_rep[0] : 99, 0);
    check_val("short_lat", ev_cyc.size() > 0 ? ev_cyc[0] - p : 99, 2);

    // Long hold on button 1, press aligned with a millisecond tick
    align_tick();
    clear_stats();
    btn_level = 4'b0010;
    p = cyc + 1;
    idle(80);
    btn_level = 4'b0000;
    idle(60);
    check_val("hold_count", ev_cyc.size(), 4);
    if (ev_cyc.size() == 4) begin
      check_val("hold_reps", ev_rep[1] + ev_rep[2] + ev_rep[3], 3);
      check_val("hold_first_rep", ev_rep[0], 0);
      check_val("hold_lat", ev_cyc[0] - p, 2);
      check_val("hold_gap1", ev_cyc[1] - ev_cyc[0], 30);
      check_val("hold_gap2", ev_cyc[2] - ev_cyc[1], 20);
      check_val("hold_gap3", ev_cyc[3] - ev_cyc[2], 20);
    end

    // Simultaneous presses in round-robin order
    apply_reset();
    idle(3);
    clear_stats();
    btn_level = 4'b1011;
    cycle();
    btn_level = 4'b0000;
    idle(8);
    btn_level = 4'b1001;
    cycle();
    btn_level = 4'b0000;
    idle(8);
    check_val("rr_count", ev_id.size(), 5);
    if (ev_id.size() == 5) begin
      check_val("rr_id0", ev_id[0], 0);
      check_val("rr_id1", ev_id[1], 1);
      check_val("rr_id2", ev_id[2], 3);
      check_val("rr_id3", ev_id[3], 0);
      check_val("rr_id4", ev_id[4], 3);
      check_val("rr_b2b_a", ev_cyc[2] - ev_cyc[0], 2);
      check_val("rr_b2b_b", ev_cyc[4] - ev_cyc[3], 1);
    end

    // Backpressure with button 0 held: output stable, repeats dropped
    align_tick();
    clear_stats();
    evt_ready = 1'b0;
    btn_level = 4'b0001;
    p = cyc + 1;
    bad = 0;
    for (int k = 0; k < 90; k++) begin
      if (k == 80) btn_level = 4'b0000;
      cycle();
      if (cyc >= p + 2 && !(evt_valid === 1'b1 && evt_id === 2'd0 && evt_repeat === 1'b0)) bad++;
    end
    check_val("stall_stable", bad, 0);
    check_val("stall_drops", n_drop, 2);
    evt_ready = 1'b1;
    idle(10);

    // Button held through reset release
    btn_level = 4'b1000;
    apply_reset();
    clear_stats();
    idle(30);
    check_val("held_rst_events", ev_cyc.size(), 0);

    // Asynchronous reset while an event is offered
    btn_level = 4'b0000;
    idle(2);
    evt_ready = 1'b0;
    btn_level = 4'b1000;
    cycle();
    btn_level = 4'b0000;
    idle(4);
    check_val("pre_rst_valid", 32'(evt_valid), 1);
    check_val("pre_rst_id", 32'(evt_id), 3);
    #2;
    rst = 1'b1;
    reset_model();
    #1;
    check_val("arst_valid", 32'(evt_valid), 0);
    check_val("arst_id", 32'(evt_id), 0);
    check_val("arst_repeat", 32'(evt_repeat), 0);
    check_val("arst_drop", 32'(drop_pulse), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    evt_ready = 1'b1;
    idle(3);

    // Randomized buttons and backpressure against the model
    for (int k = 0; k < 700; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 19) == 0) btn_level[i] = ~btn_level[i];
      evt_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    btn_level = 4'b0000;
    evt_ready = 1'b1;
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
